// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and
// the width of a counter that must reach the operand width without wrapping.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_shiftreg.sv
// Parallel-load, right-shifting register with serial input at the MSB and
// serial output from the LSB.
module serial_shiftreg #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_shift,
  input  logic             i_sin,
  output logic             o_sout,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_din;
    end else if (i_shift) begin
      r_q <= {i_sin, r_q[WIDTH-1:1]};
    end
  end

  assign o_sout = r_q[0];
  assign o_q    = r_q;

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one full adder processes one bit per cycle, LSB
// first, with the sum bits shifted back into the A register.
module serial_addsub
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_s,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_load;
  logic             w_shift;
  logic             w_a0;
  logic             w_b0;
  logic             w_sum;
  logic             w_cy;
  logic [WIDTH-1:0] w_a_q;
  logic [WIDTH-1:0] w_b_q;
  logic [WIDTH-1:0] w_b_din;

  assign w_load  = (r_state == IDLE) && i_start;
  assign w_shift = (r_state == SHIFT);
  // Subtraction is X + ~Y + 1; the +1 comes from seeding the carry with Sub.
  assign w_b_din = i_sub ? ~i_y : i_y;

  serial_shiftreg #(.WIDTH(WIDTH)) u_a (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_load),
    .i_din   (i_x),
    .i_shift (w_shift),
    .i_sin   (w_sum),
    .o_sout  (w_a0),
    .o_q     (w_a_q)
  );

  serial_shiftreg #(.WIDTH(WIDTH)) u_b (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_load),
    .i_din   (w_b_din),
    .i_shift (w_shift),
    .i_sin   (1'b0),
    .o_sout  (w_b0),
    .o_q     (w_b_q)
  );

  assign w_sum = w_a0 ^ w_b0 ^ r_carry;
  assign w_cy  = (w_a0 & w_b0) | (r_carry & (w_a0 ^ w_b0));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_carry <= i_sub;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_carry <= w_cy;
          r_cnt   <= r_cnt + 1'b1;
          // Final bit: r_carry is the carry into the MSB, w_cy the carry out.
          if (r_cnt == LAST) begin
            r_s     <= {w_sum, w_a_q[WIDTH-1:1]};
            r_cout  <= w_cy;
            r_ovf   <= r_carry ^ w_cy;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_s    = r_s;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub (WIDTH=8): stimulus pushes hand-computed
// results, a negedge monitor pops and compares on every Done pulse.
module tb_serial_addsub;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  serial_addsub #(.WIDTH(WIDTH)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_sub   (sub),
    .i_x     (x),
    .i_y     (y),
    .o_busy  (busy),
    .o_done  (done),
    .o_s     (s),
    .o_cout  (cout),
    .o_ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got S=%02h Cout=%0b Ovf=%0b, expected no Done", s, cout, ovf);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({s, cout, ovf} !== {e.s, e.cout, e.ovf}) begin
          errors++;
          $display("FAIL result: got S=%02h Cout=%0b Ovf=%0b, expected S=%02h Cout=%0b Ovf=%0b",
                   s, cout, ovf, e.s, e.cout, e.ovf);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Issue one operation; optionally inject a Start pulse mid-flight or toggle
  // the operand inputs while shifting. Checks latency, Busy width and hold.
  task automatic run_op(input logic sb, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] ya,
                        input logic [WIDTH-1:0] es, input logic ec, input logic ev,
                        input bit inject, input bit toggle);
    int lat;
    int bcnt;
    bit seen;
    exp_t e;
    e.s = es; e.cout = ec; e.ovf = ev;
    exp_q.push_back(e);
    @(negedge clk);
    sub = sb; x = xa; y = ya; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; bcnt = 0; seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        seen = 1'b1;
        lat = k - 1;
      end else begin
        if (inject) begin
          start = (k == 3);
          x = 8'h01; y = 8'h01; sub = 1'b0;
        end
        if (toggle) begin
          x = ~x; y = y ^ 8'h5A; sub = ~sub;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: got no Done within 20 cycles, expected Done after 8");
    end
    check("latency", lat, WIDTH);
    check("busy_cycles", bcnt, WIDTH);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("s_hold", s, es);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; x = '0; y = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_s", s, 8'h00);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    run_op(1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 0, 0);
    run_op(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 0, 0);
    run_op(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0, 0);
    run_op(1'b1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 0, 0);
    run_op(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 0, 0);
    run_op(1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 0, 0);
    run_op(1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 0, 0);
    run_op(1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1, 0);
    repeat (12) @(negedge clk);
    check("ignored_start_queue", exp_q.size(), 0);
    check("ignored_start_idle", busy, 1'b0);

    // Abort an operation mid-flight with an asynchronous reset.
    @(negedge clk);
    sub = 1'b0; x = 8'h11; y = 8'h22; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("pre_abort_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_s", s, 8'h00);
    check("abort_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_done_busy", busy, 1'b0);
    run_op(1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 0, 0);

    run_op(1'b0, 8'h40, 8'h02, 8'h42, 1'b0, 1'b0, 0, 1);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 The parameter SHALL be: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 Clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Reset  input  1  SHALL be the reset, asynchronous and active-high.
REQ-004 Start  input  1  SHALL request an operation and is sampled only in IDLE.
REQ-005 Sub  input  1  SHALL select the mode, sampled with Start: 0 = X+Y, 1 = X-Y (two's complement).
REQ-006 X  input  WIDTH  SHALL be operand A, sampled with Start.
REQ-007 Y  input  WIDTH  SHALL be operand B, sampled with Start.
REQ-008 Busy  output  1  SHALL be high while an operation is in progress (SHIFT state).
REQ-009 Done  output  1  SHALL be a one-cycle pulse marking S/Cout/Ovf newly valid.
REQ-010 S  output  WIDTH  SHALL be the registered result.
REQ-011 Cout  output  1  SHALL be the final carry: carry-out for add, NOT borrow for sub.
REQ-012 Ovf  output  1  SHALL be signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-014 In IDLE with Start=1 at an edge, the block SHALL do all of the following, then enter SHIFT:
- load the A shift register with X;
- load the B shift register with Y (bitwise inverted when Sub=1);
- set the carry flop to Sub;
- clear the bit counter.
REQ-015 Each SHIFT cycle SHALL do all of the following:
- add A[0], B[0] and carry in a 1-bit full adder;
- shift A and B right one place;
- insert the sum bit at A[WIDTH-1];
- store the carry-out in the carry flop;
- increment the counter.
REQ-016 On the edge that performs the WIDTH-th shift, the FSM SHALL do all of the following, then enter DONE:
- capture S = {sum, A[WIDTH-1:1]};
- capture Cout = the full-adder carry-out;
- capture Ovf = the carry-in to that bit XOR the carry-out.
REQ-017 DONE SHALL last exactly one cycle with Done=1, then return to IDLE.
REQ-018 Latency SHALL be fixed: Done is high in the cycle beginning WIDTH edges after the edge that sampled Start.
REQ-019 Busy SHALL be 1 exactly in SHIFT, i.e. WIDTH cycles per operation.
REQ-020 Start SHALL be ignored in SHIFT and DONE; no queuing.
REQ-021 The minimum issue interval SHALL be WIDTH+2 cycles.
REQ-022 X, Y and Sub changes after the sampling edge SHALL NOT affect the in-flight result.
REQ-023 S, Cout and Ovf SHALL change only on entry to DONE and hold until the next entry to DONE.
REQ-024 The result SHALL wrap modulo 2^WIDTH; no saturation.
REQ-025 The counter width SHALL be clog2(WIDTH+1) bits.
REQ-026 The counter SHALL never wrap within an operation.

Reset
REQ-027 While Reset=1, the block SHALL force all of the following regardless of Clock:
- state = IDLE;
- Busy = 0 and Done = 0;
- S = 0, Cout = 0, Ovf = 0;
- shift registers, carry flop and counter = 0.
REQ-028 Reset asserted mid-operation SHALL abort that operation with no Done pulse.
REQ-029 The first Start sampled after Reset deasserts SHALL be processed normally.

Structure
REQ-030 A shared package serial_pkg SHALL hold the following, for reuse by sibling serial blocks:
- state encodings IDLE=2'b00, SHIFT=2'b01, DONE=2'b10;
- the counter-width function.
REQ-031 One parametrised sub-module, serial_shiftreg (WIDTH, parallel load, right shift, serial in/out), SHALL be instantiated twice (A and B).
REQ-032 The full adder, carry flop, counter and FSM SHALL reside in serial_addsub.

Verification (WIDTH=8)
REQ-033 Add 0x05+0x03 -> S=0x08, Cout=0, Ovf=0; Done 8 edges after Start; Busy high 8 cycles.
REQ-034 Add 0x7F+0x01 -> S=0x80, Ovf=1, Cout=0; add 0xFF+0x01 -> S=0x00, Cout=1, Ovf=0.
REQ-035 Sub 0x03-0x05 -> S=0xFE, Cout=0, Ovf=0; sub 0x80-0x01 -> S=0x7F, Cout=1, Ovf=1.
REQ-036 Start pulsed with 0x01+0x01 while Busy during 0x10+0x20 -> single Done, S=0x30; second request ignored.
REQ-037 Reset asserted after 4 SHIFT cycles of 0x11+0x22 -> immediate Busy=0, S=0, no Done; a following 0x10+0x20 -> S=0x30.
REQ-038 X/Y toggled every cycle during SHIFT of 0x40+0x02 -> S=0x42.
